// File: rtl/mac_operand_feeder_if.sv
// Operand/MAC handshake bundle between upstream source, feeder and MAC.
// master = upstream and downstream environment, slave = mac_operand_feeder.
interface mac_operand_feeder_if #(
    parameter int DATA_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              out_ready;
    logic [DATA_W-1:0] mac_a;
    logic [DATA_W-1:0] mac_b;
    logic              mac_valid;
    logic              mac_last;
    logic              mac_clr;
    logic              vec_done;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, mac_a, mac_b, mac_valid, mac_last, mac_clr, vec_done
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, mac_a, mac_b, mac_valid, mac_last, mac_clr, vec_done
    );
endinterface

// File: rtl/mac_operand_feeder.sv
// Operand pair FIFO plus vector sequencer driving the 10x10 MAC (clear, stream, drain).
// Defining MAC_FEED_ABORT_EN adds an abort input that flushes the FIFO and restarts from IDLE.
module mac_operand_feeder #(
    parameter int DATA_W  = 10,
    parameter int DEPTH   = 8,
    parameter int VEC_LEN = 16
) (
    input logic clk,
    input logic rst,
`ifdef MAC_FEED_ABORT_EN
    input logic abort,
`endif
    mac_operand_feeder_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

    localparam logic [PTR_W:0]   FULL_CNT = {1'b1, {PTR_W{1'b0}}};
    localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [DATA_W-1:0] mem_a_r [DEPTH];
    logic [DATA_W-1:0] mem_b_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]    count_r, count_s;
    logic              in_ready_r;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [DATA_W-1:0] mac_a_r, mac_b_r;
    logic              mac_valid_r, mac_last_r, mac_clr_r, vec_done_r;
    logic              push_s, pop_s, empty_s, abort_s;
    logic              clr_s, last_s, done_s;

`ifdef MAC_FEED_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // A push arriving in an abort cycle is dropped along with the flushed contents.
    assign push_s  = bus.in_valid & in_ready_r & ~abort_s;
    assign empty_s = (count_r == {(PTR_W+1){1'b0}});

    // Next occupancy from push/pop; simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_s = count_r;
        if (push_s && !pop_s) begin
            count_s = count_r + OCC_ONE;
        end else if (pop_s && !push_s) begin
            count_s = count_r - OCC_ONE;
        end else begin
            count_s = count_r;
        end
    end

    // Sequencer next state, pair counter and the output decisions registered below.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        pop_s   = 1'b0;
        clr_s   = 1'b0;
        last_s  = 1'b0;
        done_s  = 1'b0;
        if (abort_s) begin
            state_s = IDLE;
            cnt_s   = {CNT_W{1'b0}};
            clr_s   = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!empty_s) begin
                        state_s = CLEAR;
                    end else begin
                        state_s = IDLE;
                    end
                end
                CLEAR: begin
                    clr_s   = 1'b1;
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = STREAM;
                end
                STREAM: begin
                    if (!empty_s && bus.out_ready) begin
                        pop_s = 1'b1;
                        if (cnt_r == LAST_CNT) begin
                            last_s  = 1'b1;
                            state_s = DRAIN;
                        end else begin
                            cnt_s   = cnt_r + CNT_ONE;
                            state_s = STREAM;
                        end
                    end else begin
                        state_s = STREAM;
                    end
                end
                DRAIN: begin
                    done_s = 1'b1;
                    if (!empty_s) begin
                        state_s = CLEAR;
                    end else begin
                        state_s = IDLE;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Operand storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_a_r[wr_ptr_r] <= bus.in_a;
            mem_b_r[wr_ptr_r] <= bus.in_b;
        end
    end

    // FIFO pointers, occupancy and in_ready, which tracks the registered occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {(PTR_W+1){1'b0}};
            in_ready_r <= 1'b0;
        end else if (abort_s) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {(PTR_W+1){1'b0}};
            in_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r    <= count_s;
            in_ready_r <= (count_s != FULL_CNT);
        end
    end

    // Sequencer state and pair counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Registered MAC stream; bubbles carry zero operands since the MAC has no enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            mac_a_r     <= {DATA_W{1'b0}};
            mac_b_r     <= {DATA_W{1'b0}};
            mac_valid_r <= 1'b0;
            mac_last_r  <= 1'b0;
            mac_clr_r   <= 1'b1;
            vec_done_r  <= 1'b0;
        end else begin
            mac_a_r     <= pop_s ? mem_a_r[rd_ptr_r] : {DATA_W{1'b0}};
            mac_b_r     <= pop_s ? mem_b_r[rd_ptr_r] : {DATA_W{1'b0}};
            mac_valid_r <= pop_s;
            mac_last_r  <= last_s;
            mac_clr_r   <= clr_s;
            vec_done_r  <= done_s;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.mac_a     = mac_a_r;
    assign bus.mac_b     = mac_b_r;
    assign bus.mac_valid = mac_valid_r;
    assign bus.mac_last  = mac_last_r;
    assign bus.mac_clr   = mac_clr_r;
    assign bus.vec_done  = vec_done_r;
endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench for mac_operand_feeder (VEC_LEN=4, DEPTH=8): vector table plus
// hand sequences for backpressure, back-to-back vectors, mid-vector reset and abort.
module tb_mac_operand_feeder;
    logic clk;
    logic rst;
`ifdef MAC_FEED_ABORT_EN
    logic abort;
`endif

    mac_operand_feeder_if #(.DATA_W(10)) bus ();

    mac_operand_feeder #(.DATA_W(10), .DEPTH(8), .VEC_LEN(4)) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef MAC_FEED_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference MAC: accumulator cleared by mac_clr, adds a*b every cycle.
    int acc;
    always @(posedge clk) begin
        if (bus.mac_clr === 1'b1) acc <= 0;
        else acc <= acc + int'(bus.mac_a) * int'(bus.mac_b);
    end

    typedef struct {
        logic       r, iv, ordy;
        logic [9:0] a, b;
        logic       ev, el, ec, ed, er;
        logic [9:0] ea, eb;
        logic       acc_en;
        int         eacc;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   sent;
    logic rdy_q;

    function automatic vec_t mk(bit r, bit iv, int a, int b, bit ordy,
                                bit ev, int ea, int eb, bit el, bit ec, bit ed, bit er,
                                bit acc_en = 1'b0, int eacc = 0);
        vec_t v;
        v.r = r; v.iv = iv; v.a = 10'(a); v.b = 10'(b); v.ordy = ordy;
        v.ev = ev; v.ea = 10'(ea); v.eb = 10'(eb); v.el = el; v.ec = ec; v.ed = ed; v.er = er;
        v.acc_en = acc_en; v.eacc = eacc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [24:0] outs();
        return {bus.mac_valid, bus.mac_a, bus.mac_b, bus.mac_last, bus.mac_clr, bus.vec_done, bus.in_ready};
    endfunction

    // One clock; afterwards counts the push accepted at that edge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        if (bus.in_valid && rdy_q) sent++;
    endtask

    task automatic drive_push(input int n, input int base_a, input int base_b);
        if (sent < n) begin
            bus.in_valid = 1'b1;
            bus.in_a = 10'(base_a + sent);
            bus.in_b = 10'(base_b + sent);
        end else begin
            bus.in_valid = 1'b0;
        end
        rdy_q = bus.in_ready;
    endtask

    initial begin
        int cyc_of[9];
        bit vd_at[64];
        bit clr_at[64];
        int p, nvd, first_clr, first_val, nv, exp_acc;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
`ifdef MAC_FEED_ABORT_EN
        abort = 1'b0;
`endif
        // reset for two cycles, release
        tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,1,0,0));
        tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0,1));
        // vector (1,2)(3,4)(5,6)(7,8): clr at +2, first pair at +3, acc 100
        tbl.push_back(mk(0,1,1,2,1, 0,0,0,0,0,0,1));
        tbl.push_back(mk(0,1,3,4,1, 0,0,0,0,0,0,1));
        tbl.push_back(mk(0,1,5,6,1, 0,0,0,0,1,0,1));
        tbl.push_back(mk(0,1,7,8,1, 1,1,2,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,1, 1,3,4,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,1, 1,5,6,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,1, 1,7,8,1,0,0,1));
        tbl.push_back(mk(0,0,0,0,1, 0,0,0,0,0,1,1, 1, 100));
        tbl.push_back(mk(0,0,0,0,1, 0,0,0,0,0,0,1));
        // out_ready toggling mid-vector: bubbles are zero, count moves only on issue
        tbl.push_back(mk(0,1,11,12,1, 0,0,0,0,0,0,1));
        tbl.push_back(mk(0,1,13,14,1, 0,0,0,0,0,0,1));
        tbl.push_back(mk(0,1,15,16,1, 0,0,0,0,1,0,1));
        tbl.push_back(mk(0,1,17,18,1, 1,11,12,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,1, 1,13,14,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,1, 1,15,16,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,1, 1,17,18,1,0,0,1));
        tbl.push_back(mk(0,0,0,0,1, 0,0,0,0,0,1,1, 1, 860));
        tbl.push_back(mk(0,0,0,0,1, 0,0,0,0,0,0,1));

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].r; bus.in_valid = tbl[i].iv; bus.in_a = tbl[i].a;
            bus.in_b = tbl[i].b; bus.out_ready = tbl[i].ordy;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tbl%0d", i), 32'(outs()),
                32'({tbl[i].ev, tbl[i].ea, tbl[i].eb, tbl[i].el, tbl[i].ec, tbl[i].ed, tbl[i].er}));
            if (tbl[i].acc_en) chk($sformatf("tbl%0d_acc", i), acc, tbl[i].eacc);
        end

        // 9 pairs against a stalled sink: exactly 8 accepted, then in_ready low
        sent = 0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 14; i++) begin
            drive_push(9, 20, 40);
            cycle();
        end
        chk("full_accepted", sent, 8);
        chk("full_in_ready", bus.in_ready, 0);

        // release the sink: order, vector framing and back-to-back spacing
        bus.out_ready = 1'b1;
        p = 0; nvd = 0;
        for (int c = 0; c < 40; c++) begin
            drive_push(9, 20, 40);
            cycle();
            vd_at[c] = bus.vec_done;
            clr_at[c] = bus.mac_clr;
            if (bus.vec_done) nvd++;
            if (bus.mac_valid) begin
                if (p < 9) begin
                    chk($sformatf("pair%0d", p), {bus.mac_a, bus.mac_b, bus.mac_last},
                        {10'(20 + p), 10'(40 + p), (p % 4) == 3});
                    cyc_of[p] = c;
                end
                p++;
            end
        end
        chk("pairs_issued", p, 9);
        chk("pairs_accepted", sent, 9);
        chk("vec_done_count", nvd, 2);
        if (p == 9) begin
            chk("b2b_gap", cyc_of[4] - cyc_of[3], 3);
            chk("b2b_done", vd_at[cyc_of[3] + 1], 1);
            chk("b2b_clr", clr_at[cyc_of[3] + 2], 1);
        end

        // second pair of a partial vector, then reset: no vec_done, fresh clear afterwards
        sent = 0; nv = 0;
        for (int c = 0; c < 6; c++) begin
            drive_push(1, 60, 61);
            cycle();
            if (bus.mac_valid) nv++;
        end
        chk("partial_issue", nv, 1);
        nvd = 0;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            cycle();
            chk($sformatf("rst_clr%0d", c), {bus.mac_clr, bus.mac_valid, bus.in_ready}, 3'b100);
            if (bus.vec_done) nvd++;
        end
        rst = 1'b0;
        sent = 0; nv = 0; first_clr = -1; first_val = -1;
        exp_acc = 0;
        for (int k = 0; k < 4; k++) exp_acc += (70 + k) * (80 + k);
        for (int c = 0; c < 20; c++) begin
            drive_push(4, 70, 80);
            cycle();
            if (bus.mac_clr && first_clr < 0) first_clr = c;
            if (bus.mac_valid) begin
                if (first_val < 0) first_val = c;
                nv++;
            end
            if (bus.vec_done) begin
                nvd++;
                chk("post_rst_acc", acc, exp_acc);
            end
        end
        chk("post_rst_pairs", nv, 4);
        chk("post_rst_vec_done", nvd, 1);
        chk("post_rst_clr_first", (first_clr >= 0) && (first_clr < first_val), 1);

`ifdef MAC_FEED_ABORT_EN
        // abort with 3 pairs buffered and a push presented in the same cycle
        bus.out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 6; c++) begin
            drive_push(3, 90, 91);
            cycle();
        end
        chk("abort_buffered", sent, 3);
        bus.in_valid = 1'b1; bus.in_a = 10'd99; bus.in_b = 10'd99;
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        chk("abort_out", {bus.mac_clr, bus.mac_valid, bus.vec_done, bus.in_ready}, 4'b1001);
        nv = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.mac_valid || bus.mac_clr) nv++;
        end
        chk("abort_flushed", nv, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
